// File: rtl/fir_mac_pkg.sv
// Shared widths, FSM state type and saturation limits for the FIR MAC scheduler.
// Saturation limits are consumed only when FIR_MAC_SAT_EN is defined.
package fir_mac_pkg;

    localparam int DW = 24;
    localparam int CW = 18;
    localparam int PW = 43;
    localparam int AW = 48;

    localparam logic signed [AW-1:0] SAT_MAX = 48'sh0000_007F_FFFF;
    localparam logic signed [AW-1:0] SAT_MIN = 48'shFFFF_FF80_0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/fir_mac_coef_rf.sv
// Coefficient register file: writes are accepted only while the scheduler is idle.
// The read port forwards a same-cycle write so a sample accepted with a write sees it.
module fir_mac_coef_rf
    import fir_mac_pkg::*;
#(
    parameter int NTAPS = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(NTAPS)-1:0] addr,
    input  logic [CW-1:0]            wdata,
    input  logic                     busy,
    input  logic [$clog2(NTAPS)-1:0] rd_addr,
    output logic [CW-1:0]            rd_data
);

    logic [CW-1:0] coef [NTAPS];
    logic          wr_en;

    assign wr_en   = we && !busy;
    assign rd_data = (wr_en && addr == rd_addr) ? wdata : coef[rd_addr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (wr_en) begin
            coef[addr] <= wdata;
        end
    end

endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR: issues NTAPS products to an external pipelined multiplier
// and accumulates them as valid tags emerge. FIR_MAC_SAT_EN selects saturating output.
module fir_mac_sched
    import fir_mac_pkg::*;
#(
    parameter int NTAPS   = 16,
    parameter int MUL_LAT = 3,
    parameter int CSHIFT  = 17
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DW-1:0]            s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DW-1:0]            m_data,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [CW-1:0]            coef_wdata,
    output logic                     busy,
    output logic                     mul_ce,
    output logic [DW-1:0]            mul_a,
    output logic [CW-1:0]            mul_b,
    input  logic [PW-1:0]            mul_p
);

    localparam int IW  = $clog2(NTAPS);
    localparam int DCW = $clog2(MUL_LAT + 1);

    state_t                 state;
    logic [IW-1:0]          wr_ptr;
    logic [IW-1:0]          cnt;
    logic [IW-1:0]          nxt_k;
    logic [IW-1:0]          coef_rd_addr;
    logic [CW-1:0]          coef_rd;
    logic [DCW-1:0]         dcnt;
    logic [MUL_LAT-1:0]     tags;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_next;
    logic [DW-1:0]          xline [NTAPS];

    function automatic logic [DW-1:0] fmt(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> CSHIFT;
`ifdef FIR_MAC_SAT_EN
        if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < SAT_MIN) begin
            s = SAT_MIN;
        end
`endif
        return s[DW-1:0];
    endfunction

    // Operands are registered one cycle ahead, so look up tap k+1 while tap k is on the bus.
    assign nxt_k        = cnt + IW'(1);
    assign coef_rd_addr = (state == IDLE) ? '0 : nxt_k;

    fir_mac_coef_rf #(
        .NTAPS (NTAPS)
    ) u_coef_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (coef_we),
        .addr    (coef_addr),
        .wdata   (coef_wdata),
        .busy    (busy),
        .rd_addr (coef_rd_addr),
        .rd_data (coef_rd)
    );

    always_comb begin
        acc_next = acc;
        if (mul_ce && tags[MUL_LAT-1]) begin
            acc_next = acc + {{(AW-PW){mul_p[PW-1]}}, mul_p};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            cnt     <= '0;
            dcnt    <= '0;
            tags    <= '0;
            acc     <= '0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                xline[i] <= '0;
            end
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            busy    <= 1'b0;
            mul_ce  <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else begin
            if (mul_ce) begin
                tags <= (tags << 1) | MUL_LAT'(state == ISSUE);
                acc  <= acc_next;
            end
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        xline[wr_ptr] <= s_data;
                        acc     <= '0;
                        mul_a   <= s_data;
                        mul_b   <= coef_rd;
                        mul_ce  <= 1'b1;
                        cnt     <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == IW'(NTAPS - 1)) begin
                        mul_a <= '0;
                        mul_b <= '0;
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt   <= nxt_k;
                        mul_a <= xline[wr_ptr - nxt_k];
                        mul_b <= coef_rd;
                    end
                end
                DRAIN: begin
                    // The last product is accumulated on this same edge, hence acc_next.
                    if (dcnt == DCW'(MUL_LAT - 1)) begin
                        mul_ce  <= 1'b0;
                        m_valid <= 1'b1;
                        m_data  <= fmt(acc_next);
                        state   <= OUT;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        wr_ptr  <= wr_ptr + IW'(1);
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched with a pipelined multiplier model and a
// convolution reference model; honours FIR_MAC_SAT_EN for expected output values.
module tb_fir_mac_sched;

    localparam int NTAPS   = 16;
    localparam int MUL_LAT = 3;
    localparam int CSHIFT  = 17;
    localparam int IW      = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [23:0]   s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [23:0]   m_data;
    logic          coef_we = 1'b0;
    logic [IW-1:0] coef_addr = '0;
    logic [17:0]   coef_wdata = '0;
    logic          busy;
    logic          mul_ce;
    logic [23:0]   mul_a;
    logic [17:0]   mul_b;
    logic [42:0]   mul_p;

    int checks = 0;
    int errors = 0;

    logic [17:0] coef_m [NTAPS];
    logic [23:0] hist [$];

    fir_mac_sched #(
        .NTAPS   (NTAPS),
        .MUL_LAT (MUL_LAT),
        .CSHIFT  (CSHIFT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .busy       (busy),
        .mul_ce     (mul_ce),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p)
    );

    always #5 clk = ~clk;

    // Attached 24x18 multiplier: MUL_LAT registers, all gated by mul_ce.
    logic signed [42:0] pipe [MUL_LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            pipe[0] <= $signed(mul_a) * $signed({1'b0, mul_b});
            for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_p = pipe[MUL_LAT-1];

    // y[n] = sum_k coef[k] * x[n-k], then arithmetic shift and wrap or saturate.
    function automatic logic [23:0] model_out();
        longint acc;
        longint s;
        acc = 0;
        for (int k = 0; k < hist.size(); k++)
            acc += longint'($signed(hist[k])) * longint'(coef_m[k]);
        s = acc >>> CSHIFT;
`ifdef FIR_MAC_SAT_EN
        if (s > 64'sd8388607) s = 64'sd8388607;
        else if (s < -64'sd8388608) s = -64'sd8388608;
`endif
        return s[23:0];
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int k = 0; k < NTAPS; k++) coef_m[k] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        s_valid = 1'b0;
        coef_we = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic write_coef(input logic [IW-1:0] a, input logic [17:0] d);
        @(negedge clk);
        coef_we = 1'b1;
        coef_addr = a;
        coef_wdata = d;
        coef_m[a] = d;
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic run_sample(input logic [23:0] d, input int stall, input bit cw,
                              input logic [IW-1:0] ca, input logic [17:0] cd,
                              input bit drop, output logic [23:0] got);
        logic [23:0] exp;
        int n;
        bit seen;
        got = 'x;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            $display("FAIL s_ready_idle: got %b, expected 1", s_ready);
            errors++;
        end
        s_valid = 1'b1;
        s_data = d;
        coef_we = cw;
        coef_addr = ca;
        coef_wdata = cd;
        m_ready = (stall == 0);
        if (cw) coef_m[ca] = cd;
        hist.push_front(d);
        if (hist.size() > NTAPS) void'(hist.pop_back());
        exp = model_out();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 1) begin
                s_valid = 1'b0;
                coef_we = 1'b0;
                if (drop) begin
                    coef_we = 1'b1;
                    coef_addr = ca;
                    coef_wdata = cd;
                end
            end
            if (n == 2) begin
                coef_we = 1'b0;
                checks++;
                if (s_ready !== 1'b0 || busy !== 1'b1 || mul_ce !== 1'b1) begin
                    $display("FAIL issue_flags: s_ready=%b busy=%b mul_ce=%b, expected 0 1 1",
                             s_ready, busy, mul_ce);
                    errors++;
                end
            end
            if (m_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            $display("FAIL m_valid_timeout: no m_valid within %0d cycles", n);
            errors++;
            m_ready = 1'b0;
            return;
        end
        checks++;
        if (n != NTAPS + MUL_LAT + 1) begin
            $display("FAIL latency: got %0d cycles, expected %0d", n, NTAPS + MUL_LAT + 1);
            errors++;
        end
        checks++;
        if (m_data !== exp) begin
            $display("FAIL m_data: got %h, expected %h", m_data, exp);
            errors++;
        end
        got = m_data;
        for (int i = 0; i < stall; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== got || s_ready !== 1'b0 || mul_ce !== 1'b0) begin
                $display("FAIL stall_hold: m_valid=%b m_data=%h s_ready=%b mul_ce=%b, expected 1 %h 0 0",
                         m_valid, m_data, s_ready, mul_ce, got);
                errors++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL post_handshake: m_valid=%b s_ready=%b busy=%b, expected 0 1 0",
                     m_valid, s_ready, busy);
            errors++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 24'h0 || busy !== 1'b0 ||
            mul_ce !== 1'b0 || mul_a !== 24'h0 || mul_b !== 18'h0) begin
            $display("FAIL reset_values: s_ready=%b m_valid=%b m_data=%h busy=%b mul_ce=%b mul_a=%h mul_b=%h, expected 1 0 0 0 0 0 0",
                     s_ready, m_valid, m_data, busy, mul_ce, mul_a, mul_b);
            errors++;
        end
    endtask

    task automatic test_impulse();
        logic [23:0] got;
        logic [23:0] want;
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(IW'(k), 18'(k + 1));
        for (int j = 0; j <= NTAPS; j++) begin
            run_sample((j == 0) ? 24'h020000 : 24'h0, 0, 1'b0, '0, '0, 1'b0, got);
            want = (j < NTAPS) ? 24'(j + 1) : 24'h0;
            checks++;
            if (got !== want) begin
                $display("FAIL impulse[%0d]: got %h, expected %h", j, got, want);
                errors++;
            end
        end
    endtask

    task automatic test_reset_abort();
        bit saw;
        logic [23:0] got;
        do_reset();
        write_coef(0, 18'd5);
        @(negedge clk);
        s_valid = 1'b1;
        s_data = 24'h040000;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || mul_ce !== 1'b0 || m_valid !== 1'b0) begin
            $display("FAIL abort_flags: s_ready=%b busy=%b mul_ce=%b m_valid=%b, expected 1 0 0 0",
                     s_ready, busy, mul_ce, m_valid);
            errors++;
        end
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_valid === 1'b1) saw = 1'b1;
        end
        m_ready = 1'b0;
        checks++;
        if (saw) begin
            $display("FAIL abort_no_result: got m_valid=1 after abort, expected none");
            errors++;
        end
        // Coefficients were cleared by the reset, so this sample must yield zero.
        run_sample(24'h040000, 0, 1'b0, '0, '0, 1'b0, got);
    endtask

    task automatic test_backpressure();
        logic [23:0] got;
        logic [31:0] r;
        r = $urandom();
        run_sample(r[23:0], 5, 1'b0, '0, '0, 1'b0, got);
    endtask

    task automatic test_dropped_write();
        logic [23:0] got;
        do_reset();
        write_coef(0, 18'd2);
        run_sample(24'h0, 0, 1'b0, '0, 18'd7, 1'b1, got);
        run_sample(24'h020000, 0, 1'b0, '0, '0, 1'b0, got);
        checks++;
        if (got !== 24'd2) begin
            $display("FAIL dropped_write: got %h, expected 000002", got);
            errors++;
        end
    endtask

    task automatic test_same_cycle_write();
        logic [23:0] got;
        do_reset();
        run_sample(24'h020000, 0, 1'b1, '0, 18'd9, 1'b0, got);
        checks++;
        if (got !== 24'd9) begin
            $display("FAIL same_cycle_write: got %h, expected 000009", got);
            errors++;
        end
    endtask

    task automatic test_overflow();
        logic [23:0] got;
        logic [23:0] want;
        do_reset();
        write_coef(0, 18'h3FFFF);
        run_sample(24'h7FFFFF, 0, 1'b0, '0, '0, 1'b0, got);
`ifdef FIR_MAC_SAT_EN
        want = 24'h7FFFFF;
`else
        want = 24'hFFFFBE;
`endif
        checks++;
        if (got !== want) begin
            $display("FAIL overflow: got %h, expected %h", got, want);
            errors++;
        end
    endtask

    task automatic test_sign_wrap();
        logic [23:0] got;
        logic [31:0] r;
        do_reset();
        write_coef(0, 18'd2);
        run_sample(24'hFFFFFF, 0, 1'b0, '0, '0, 1'b0, got);
        checks++;
        if (got !== 24'hFFFFFF) begin
            $display("FAIL sign_neg1: got %h, expected ffffff", got);
            errors++;
        end
        for (int k = 0; k < NTAPS; k++) begin
            r = $urandom();
            write_coef(IW'(k), 18'(r[13:0]));
        end
        for (int j = 0; j < NTAPS + 1; j++) begin
            r = $urandom();
            run_sample(r[23:0], 0, 1'b0, '0, '0, 1'b0, got);
        end
    endtask

    task automatic test_random();
        logic [23:0] got;
        logic [31:0] r;
        logic [31:0] c;
        bit cw;
        bit drop;
        for (int k = 0; k < NTAPS; k++) begin
            r = $urandom();
            write_coef(IW'(k), r[17:0]);
        end
        for (int j = 0; j < 24; j++) begin
            r = $urandom();
            c = $urandom();
            cw = ($urandom_range(0, 3) == 0);
            drop = !cw && ($urandom_range(0, 3) == 0);
            run_sample(r[23:0], int'($urandom_range(0, 3)), cw, c[IW-1:0], c[31:14], drop, got);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_backpressure();
        test_reset_abort();
        test_dropped_write();
        test_same_cycle_write();
        test_overflow();
        test_sign_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
